// File: rtl/seg_blink_scanner.sv
// seg_blink_scanner: time-multiplexed digit scanner with EDIT/RUN/FINISH/OFF
// display modes, fixed separator positions and a tick-driven blink phase.
// Output code and digit enable are registered together at each scan advance.
module seg_blink_scanner #(
  parameter int               DIGITS       = 8,
  parameter int               SCAN_DIV     = 4,
  parameter int               BLINK_PERIOD = 100,
  parameter int               BLINK_DUTY   = 50,
  parameter logic [DIGITS-1:0] SEP_MASK    = DIGITS'(8'b0010_0100),
  parameter logic [3:0]       SEP_CODE     = 4'hB,
  parameter logic [3:0]       BLANK_CODE   = 4'hF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [4*DIGITS-1:0]        run_val_i,
  input  logic [4*DIGITS-1:0]        edit_val_i,
  input  logic [1:0]                 mode_i,
  input  logic [$clog2(DIGITS)-1:0]  cursor_i,
  input  logic                       blink_tick_i,
  output logic [3:0]                 digit_code_o,
  output logic [DIGITS-1:0]          an_n_o,
  output logic                       frame_start_o
);

  localparam int IW = $clog2(DIGITS);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(BLINK_PERIOD - 1);

  typedef enum logic [1:0] {
    MODE_EDIT   = 2'b00,
    MODE_RUN    = 2'b01,
    MODE_FINISH = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  // State registers and their next-state values
  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;      // digit loaded at the next advance
  logic [PW-1:0]     phase_q, phase_d;
  logic [IW-1:0]     cursor_q;          // previous cursor, for change detect
  logic [1:0]        mode_q;            // previous mode, for change detect
  logic [3:0]        code_q, code_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_q, frame_d;

  mode_e                mode_sel;
  logic                 advance;
  logic                 blink_on;
  logic [4*DIGITS-1:0]  cand_flat;      // code each position would show now

  assign mode_sel = mode_e'(mode_i);
  assign blink_on = (int'(phase_q) < BLINK_DUTY);

  // Per-position display code from the current mode, inputs and blink phase
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] code_c;

    // Resolve separator, blanking and value selection for this position
    always_comb begin
      code_c = BLANK_CODE;
      if (mode_sel != MODE_OFF && SEP_MASK[gi]) begin
        code_c = SEP_CODE;
      end else begin
        case (mode_sel)
          MODE_EDIT:   code_c = (int'(cursor_i) == gi && !blink_on) ? BLANK_CODE
                                                                    : edit_val_i[4*gi +: 4];
          MODE_RUN:    code_c = run_val_i[4*gi +: 4];
          MODE_FINISH: code_c = blink_on ? run_val_i[4*gi +: 4] : BLANK_CODE;
          default:     code_c = BLANK_CODE;
        endcase
      end
    end

    assign cand_flat[4*gi +: 4] = code_c;
  end

  // Next-state: scan divider/index, registered outputs and blink phase
  always_comb begin
    advance = (div_q == DIV_LAST);
    div_d   = advance ? '0 : div_q + 1'b1;
    idx_d   = idx_q;
    code_d  = code_q;
    an_d    = an_q;
    frame_d = 1'b0;
    if (advance) begin
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      code_d  = cand_flat[4*idx_q +: 4];
      an_d    = ~(DIGITS'(1) << idx_q);
      frame_d = (idx_q == '0);
    end

    // A cursor or mode change restarts the phase and swallows any tick
    phase_d = phase_q;
    if (cursor_i != cursor_q || mode_i != mode_q) begin
      phase_d = '0;
    end else if (blink_tick_i) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q    <= '0;
      idx_q    <= '0;
      phase_q  <= '0;
      cursor_q <= '0;
      mode_q   <= '0;
      code_q   <= BLANK_CODE;
      an_q     <= '1;
      frame_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      cursor_q <= cursor_i;
      mode_q   <= mode_i;
      code_q   <= code_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign digit_code_o  = code_q;
  assign an_n_o        = an_q;
  assign frame_start_o = frame_q;

endmodule

// File: tb/tb_seg_blink_scanner.sv
// Randomized scoreboard bench for seg_blink_scanner with default parameters.
module tb_seg_blink_scanner;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int PERIOD   = 100;
  localparam int DUTY     = 50;
  localparam logic [7:0] SEP = 8'b0010_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] run_val = '0;
  logic [31:0] edit_val = '0;
  logic [1:0]  mode = 2'b01;
  logic [2:0]  cursor = '0;
  logic        blink_tick = 1'b0;
  logic [3:0]  digit_code;
  logic [7:0]  an_n;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_blink_scanner dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .run_val_i     (run_val),
    .edit_val_i    (edit_val),
    .mode_i        (mode),
    .cursor_i      (cursor),
    .blink_tick_i  (blink_tick),
    .digit_code_o  (digit_code),
    .an_n_o        (an_n),
    .frame_start_o (frame_start)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         due;
    logic [3:0] code;
    logic [7:0] an;
    logic       fs;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [3:0] held_code = 4'hF;
  logic [7:0] held_an   = 8'hFF;
  logic       in_reset  = 1'b1;
  int         edge_cnt  = 0;

  // Reference model state: blink ticks counted since the last phase restart
  int         ticks = 0;
  logic [1:0] prev_mode = '0;
  logic [2:0] prev_cur  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_code(input int d, input logic [1:0] m, input int c,
                                          input logic [31:0] rv, input logic [31:0] ev,
                                          input bit on);
    logic [7:0] s;
    s = SEP;
    if (m == 2'b11) return 4'hF;
    if (s[d]) return 4'hB;
    case (m)
      2'b00:   return (d == c && !on) ? 4'hF : ev[4*d +: 4];
      2'b01:   return rv[4*d +: 4];
      default: return on ? rv[4*d +: 4] : 4'hF;
    endcase
  endfunction

  // Rising edges since reset release
  always @(posedge clk) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Drive one cycle of inputs and predict the edge they will be sampled on
  task automatic step(input logic [1:0] m, input logic [2:0] c, input logic [31:0] rv,
                      input logic [31:0] ev, input logic t);
    int   n;
    int   d;
    bit   on;
    exp_t e;
    @(posedge clk);
    #2;
    mode = m; cursor = c; run_val = rv; edit_val = ev; blink_tick = t;
    n  = edge_cnt + 1;
    on = (ticks % PERIOD) < DUTY;
    if (n % SCAN_DIV == 0) begin
      d      = (n / SCAN_DIV - 1) % DIGITS;
      e.due  = n;
      e.code = ref_code(d, m, int'(c), rv, ev, on);
      e.an   = ~(8'(1) << d);
      e.fs   = (d == 0);
      q.push_back(e);
    end
    if (m != prev_mode || c != prev_cur) ticks = 0;
    else if (t) ticks++;
    prev_mode = m;
    prev_cur  = c;
  endtask

  // Assert reset between clock edges, check it took effect, then release
  task automatic pulse_reset(input int hold);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("rst_code", digit_code, 4'hF);
    chk("rst_an_n", an_n, 8'hFF);
    chk("rst_frame", frame_start, 1'b0);
    repeat (hold) @(posedge clk);
    #2;
    q.delete();
    held_code  = 4'hF;
    held_an    = 8'hFF;
    ticks      = 0;
    prev_mode  = mode;
    prev_cur   = cursor;
    blink_tick = 1'b0;
    rst_n      = 1'b1;
    in_reset   = 1'b0;
  endtask

  // Monitor: pop on a scan advance (enable change or due time), else check hold
  always @(negedge clk) begin
    if (!in_reset) begin
      if ((q.size() > 0 && q[0].due == edge_cnt) || an_n !== held_an) begin
        if (q.size() == 0) begin
          chk("unexpected_advance", an_n, held_an);
        end else begin
          mon_e = q.pop_front();
          chk("advance_time", edge_cnt, mon_e.due);
          chk("code", digit_code, mon_e.code);
          chk("an_n", an_n, mon_e.an);
          chk("frame_start", frame_start, mon_e.fs);
          held_code = mon_e.code;
          held_an   = mon_e.an;
        end
      end else begin
        chk("hold_code", digit_code, held_code);
        chk("frame_idle", frame_start, 1'b0);
      end
    end
  end

  initial begin
    logic [1:0]  m;
    logic [2:0]  c;
    logic [31:0] ev;
    int          len;

    pulse_reset(2);

    // RUN with separators in the value: steady digits, phase irrelevant
    repeat (80) step(2'd1, 3'($urandom_range(0, 7)), 32'h12B34B56, $urandom, 1'($urandom_range(0, 1)));

    // EDIT cursor 3: blinks through full on/off phases
    repeat (300) step(2'd0, 3'd3, $urandom, 32'h00B00B00, 1'b1);

    // EDIT cursor moved 1 -> 4 once the off phase is reached
    ev = $urandom;
    repeat (70) step(2'd0, 3'd1, $urandom, ev, 1'b1);
    repeat (60) step(2'd0, 3'd4, $urandom, ev, 1'b1);

    // FINISH: value digits blink together, separators constant
    repeat (300) step(2'd2, 3'd0, 32'h99B59B59, $urandom, 1'b1);

    // OFF: everything dark while scanning continues
    repeat (64) step(2'd3, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));

    // Reset in the middle of a frame
    repeat (13) step(2'd1, 3'd0, $urandom, $urandom, 1'b0);
    pulse_reset(1);

    // Mixed random segments with occasional cursor changes
    for (int k = 0; k < 20; k++) begin
      m   = 2'($urandom_range(0, 3));
      c   = 3'($urandom_range(0, 7));
      len = $urandom_range(20, 150);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 40) == 0) c = 3'($urandom_range(0, 7));
        step(m, c, $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_blink_scanner.md
SEG_BLINK_SCANNER -- requirements
Module: seg_blink_scanner

Interface
REQ-001 Parameter DIGITS, default 8: number of scanned digit positions (2..16).
REQ-002 Parameter SCAN_DIV, default 4: clk cycles each digit is held.
REQ-003 Parameter BLINK_PERIOD, default 100: blink_tick pulses per blink cycle.
REQ-004 Parameter BLINK_DUTY, default 50: ticks of each blink cycle that are the "on" phase.
REQ-005 Parameter SEP_MASK, default 8'b0010_0100: a 1 marks a separator position.
REQ-006 Parameter SEP_CODE, default 4'hB: code driven at separator positions.
REQ-007 Parameter BLANK_CODE, default 4'hF: code for a dark digit.
REQ-008 clk  input  1  sole clock; all state updates on rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 run_val  input  4*DIGITS  running value; nibble i belongs to digit i.
REQ-011 edit_val  input  4*DIGITS  value under edit; same nibble layout.
REQ-012 mode  input  2  00 EDIT, 01 RUN, 10 FINISH, 11 OFF.
REQ-013 cursor  input  clog2(DIGITS)  digit index blinking in EDIT.
REQ-014 blink_tick  input  1  single-cycle timebase pulse advancing the blink phase.
REQ-015 digit_code  output  4  registered code for the currently enabled digit.
REQ-016 an_n  output  DIGITS  registered one-hot-low digit enable.
REQ-017 frame_start  output  1  one-cycle pulse when digit 0 becomes enabled.

Function
REQ-018 A divider counts 0..SCAN_DIV-1; at terminal count, scan index advances by 1 and wraps from DIGITS-1 to 0.
REQ-019 When the index advances, digit_code and an_n SHALL both update on the same edge, so code and enable never mismatch.
REQ-020 Inputs are sampled only at index advance; changes between advances are not visible until the next advance.
REQ-021 Blink phase counter increments on each blink_tick and wraps from BLINK_PERIOD-1 to 0; "on" means phase < BLINK_DUTY.
REQ-022 Separator positions (SEP_MASK bit set) always show SEP_CODE in EDIT, RUN and FINISH.
REQ-023 EDIT: non-separator digit i shows edit_val nibble i, except digit i == cursor, which shows BLANK_CODE during the off phase.
REQ-024 RUN: non-separator digits show run_val nibbles unconditionally; blink phase has no effect.
REQ-025 FINISH: all non-separator digits show run_val nibbles during the on phase and BLANK_CODE during the off phase.
REQ-026 OFF: every position, separators included, shows BLANK_CODE; scanning and an_n continue.
REQ-027 A change of cursor value (sampled every clk) SHALL reset the blink phase to 0, so a newly selected digit is visible immediately; a simultaneous blink_tick is ignored.
REQ-028 A change of mode SHALL likewise reset the blink phase to 0.
REQ-029 A cursor at a separator position or at an index >= DIGITS blinks nothing.
REQ-030 frame_start is high for exactly one clk, coincident with the edge where an_n enables digit 0.
REQ-031 blink_tick held high for several cycles advances the phase once per cycle.

Reset
REQ-032 While rst_n is low: divider, index, phase = 0; digit_code = BLANK_CODE; an_n = all ones; frame_start = 0.
REQ-033 Reset asserted mid-scan SHALL take effect immediately and asynchronously.
REQ-034 After release, the first index advance occurs SCAN_DIV cycles later and enables digit 0 with frame_start high.

Verification
REQ-035 Defaults, mode RUN, run_val 32'h12B34B56 -> digits 0..7 show 6,5,B,4,3,B,2,1; each an_n pattern is held 4 clk; frame_start once per 32 clk.
REQ-036 EDIT, cursor 3, edit_val 32'h00B00B00, 100 ticks -> digit 3 shows 0 for 50 ticks, then F for 50 ticks; all other digits are steady.
REQ-037 EDIT, cursor moved 1 -> 4 during the off phase -> phase resets; digit 4 is visible on its next scan slot.
REQ-038 FINISH with run_val 32'h99B59B59 -> value digits alternate with F every 50 ticks; positions 2 and 5 are constant B.
REQ-039 OFF -> every slot shows F, including separators; an_n keeps rotating.
REQ-040 rst_n pulsed low mid-frame -> outputs reach reset values asynchronously; after release, digit 0 is enabled after 4 clk.
